// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
//
// Main control FSM for a multicycle MIPS datapath. Each instruction is
// walked through fetch / decode / execute / memory / writeback. The FSM
// drives the datapath strobes and the 2-bit alu_op that the ALU control
// decoder consumes (00 add, 01 sub, 10 R-type via funct, 11 ori).
// Memory states wait on a ready handshake.
//
// Parameters
//   USE_MEM_READY  1: memory states hold until mem_ready=1
//                  0: mem_ready is ignored and treated as always 1
//
// Ports
//   clk            in   system clock, all state updates on rising edge
//   reset          in   synchronous, active-high reset
//   opcode[5:0]    in   instr[31:26] from the instruction register
//   mem_ready      in   memory completes the current read/write this cycle
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load if ALU zero (beq)
//   i_or_d         out  0 = memory address from PC, 1 = from ALUOut
//   mem_read       out  memory read request
//   mem_write      out  memory write request
//   ir_write       out  load instruction register
//   mem_to_reg     out  1 = write-back data from MDR, 0 = from ALUOut
//   reg_dst        out  1 = rd, 0 = rt
//   reg_write      out  register file write enable
//   alu_src_a      out  0 = PC, 1 = register A
//   alu_src_b[1:0] out  00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   pc_source[1:0] out  00 ALU result, 01 ALUOut, 10 jump target
//   alu_op[1:0]    out  00 add, 01 sub, 10 funct, 11 ori
//   illegal_op     out  one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]     out  current state encoding (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_control #(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [1:0] alu_op,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ORIEX  = 4'd9,
      IMMWB  = 4'd10,
      JUMP   = 4'd11,
      ADDIEX = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   state_t state_q;
   state_t state_d;
   logic   eff_ready;

   // With the handshake disabled every memory access completes in one cycle.
   assign eff_ready = USE_MEM_READY ? mem_ready : 1'b1;

   // Debug view of the state; reads zero while reset is held.
   assign state = reset ? 4'd0 : state_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Encodings 13-15 are unreachable and fall back to FETCH.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = eff_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_ADDI:      state_d = ADDIEX;
               OP_ORI:       state_d = ORIEX;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = eff_ready ? MEMWB : MEMRD;
         MEMWB:   state_d = FETCH;
         MEMWR:   state_d = eff_ready ? FETCH : MEMWR;
         EXEC:    state_d = ALUWB;
         ALUWB:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         ORIEX:   state_d = IMMWB;
         IMMWB:   state_d = FETCH;
         JUMP:    state_d = FETCH;
         ADDIEX:  state_d = IMMWB;
         default: state_d = FETCH;
      endcase
   end

   // Moore output decode. The instruction-register and PC loads in FETCH
   // only fire once memory has delivered the word. Reset overrides
   // everything so no strobe leaks out in the reset cycle.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = 2'b00;
      illegal_op    = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = eff_ready;
            pc_write  = eff_ready;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: illegal_op = 1'b0;
               default: illegal_op = 1'b1;
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         ORIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
         end
         IMMWB: begin
            reg_write = 1'b1;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         default: begin
            pc_write = 1'b0;
         end
      endcase
      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         i_or_d        = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         mem_to_reg    = 1'b0;
         reg_dst       = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         pc_source     = 2'b00;
         alu_op        = 2'b00;
         illegal_op    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Directed, table-driven bench for the multicycle MIPS control FSM. Each
// table row is one clock cycle: the inputs held during that cycle and the
// state and control word expected in it. A few hand-written sequences cover
// reset during a stalled store and the handshake-disabled build.
//
// Control word packing (msb to lsb):
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   pc_source[1:0], alu_op[1:0], illegal_op
// -----------------------------------------------------------------------------
module tb_mips_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   localparam logic [16:0] C_ZERO    = 17'b000000_0000_00_00_00_0;
   localparam logic [16:0] C_FETCH   = 17'b100101_0000_01_00_00_0;
   localparam logic [16:0] C_FSTALL  = 17'b000100_0000_01_00_00_0;
   localparam logic [16:0] C_DECODE  = 17'b000000_0000_11_00_00_0;
   localparam logic [16:0] C_DECILL  = 17'b000000_0000_11_00_00_1;
   localparam logic [16:0] C_MEMADR  = 17'b000000_0001_10_00_00_0;
   localparam logic [16:0] C_MEMRD   = 17'b001100_0000_00_00_00_0;
   localparam logic [16:0] C_MEMWB   = 17'b000000_1010_00_00_00_0;
   localparam logic [16:0] C_MEMWR   = 17'b001010_0000_00_00_00_0;
   localparam logic [16:0] C_EXEC    = 17'b000000_0001_00_00_10_0;
   localparam logic [16:0] C_ALUWB   = 17'b000000_0110_00_00_00_0;
   localparam logic [16:0] C_BRANCH  = 17'b010000_0001_00_01_01_0;
   localparam logic [16:0] C_ORIEX   = 17'b000000_0001_10_00_11_0;
   localparam logic [16:0] C_IMMWB   = 17'b000000_0010_00_00_00_0;
   localparam logic [16:0] C_JUMP    = 17'b100000_0000_00_10_00_0;
   localparam logic [16:0] C_ADDIEX  = 17'b000000_0001_10_00_00_0;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  expState;
      logic [16:0] expCtrl;
   } vec_t;

   logic clk;
   logic reset;
   logic [5:0] opcode;
   logic mem_ready;

   logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, pc_source, alu_op;
   logic [3:0] state;

   logic pc_write_nr, pc_write_cond_nr, i_or_d_nr, mem_read_nr, mem_write_nr, ir_write_nr;
   logic mem_to_reg_nr, reg_dst_nr, reg_write_nr, alu_src_a_nr, illegal_op_nr;
   logic [1:0] alu_src_b_nr, pc_source_nr, alu_op_nr;
   logic [3:0] state_nr;

   logic [16:0] ctrl;
   logic [16:0] ctrlNr;

   int checkCount;
   int passCount;
   vec_t vecs[$];

   // Handshake-enabled instance exercised by the table.
   mips_multicycle_control #(.USE_MEM_READY(1'b1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
      .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
   );

   // Handshake-disabled instance sharing the same inputs.
   mips_multicycle_control #(.USE_MEM_READY(1'b0)) dut_nr (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write_nr), .pc_write_cond(pc_write_cond_nr), .i_or_d(i_or_d_nr),
      .mem_read(mem_read_nr), .mem_write(mem_write_nr), .ir_write(ir_write_nr),
      .mem_to_reg(mem_to_reg_nr), .reg_dst(reg_dst_nr), .reg_write(reg_write_nr),
      .alu_src_a(alu_src_a_nr), .alu_src_b(alu_src_b_nr), .pc_source(pc_source_nr),
      .alu_op(alu_op_nr), .illegal_op(illegal_op_nr), .state(state_nr)
   );

   assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                  pc_source, alu_op, illegal_op};
   assign ctrlNr = {pc_write_nr, pc_write_cond_nr, i_or_d_nr, mem_read_nr, mem_write_nr,
                    ir_write_nr, mem_to_reg_nr, reg_dst_nr, reg_write_nr, alu_src_a_nr,
                    alu_src_b_nr, pc_source_nr, alu_op_nr, illegal_op_nr};

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void addVec(input logic rst, input logic [5:0] op, input logic rdy,
                                  input logic [3:0] st, input logic [16:0] c);
      vec_t v;
      v.rst      = rst;
      v.op       = op;
      v.rdy      = rdy;
      v.expState = st;
      v.expCtrl  = c;
      vecs.push_back(v);
   endfunction

   // Drive one cycle of inputs right after the rising edge.
   task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic rdy);
      reset     = rst;
      opcode    = op;
      mem_ready = rdy;
   endtask

   // Compare state and control word; outputs are sampled on the falling edge.
   task automatic checkOutput(input string name, input logic [3:0] actState,
                              input logic [16:0] actCtrl, input logic [3:0] expState,
                              input logic [16:0] expCtrl);
      checkCount++;
      if (actState === expState) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s state: got %0d, expected %0d", name, actState, expState);
      end
      checkCount++;
      if (actCtrl === expCtrl) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s ctrl: got %b, expected %b", name, actCtrl, expCtrl);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      opcode     = OP_R;
      mem_ready  = 1'b1;

      addVec(1'b1, OP_R,    1'b1, 4'd0,  C_ZERO);
      addVec(1'b0, OP_R,    1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_R,    1'b1, 4'd1,  C_DECODE);
      addVec(1'b0, OP_R,    1'b1, 4'd6,  C_EXEC);
      addVec(1'b0, OP_R,    1'b1, 4'd7,  C_ALUWB);
      addVec(1'b0, OP_LW,   1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_LW,   1'b1, 4'd1,  C_DECODE);
      addVec(1'b0, OP_LW,   1'b1, 4'd2,  C_MEMADR);
      addVec(1'b0, OP_LW,   1'b0, 4'd3,  C_MEMRD);
      addVec(1'b0, OP_LW,   1'b0, 4'd3,  C_MEMRD);
      addVec(1'b0, OP_LW,   1'b0, 4'd3,  C_MEMRD);
      addVec(1'b0, OP_LW,   1'b1, 4'd3,  C_MEMRD);
      addVec(1'b0, OP_LW,   1'b1, 4'd4,  C_MEMWB);
      addVec(1'b0, OP_BEQ,  1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_BEQ,  1'b1, 4'd1,  C_DECODE);
      addVec(1'b0, OP_BEQ,  1'b1, 4'd8,  C_BRANCH);
      addVec(1'b0, OP_ORI,  1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_ORI,  1'b1, 4'd1,  C_DECODE);
      addVec(1'b0, OP_ORI,  1'b1, 4'd9,  C_ORIEX);
      addVec(1'b0, OP_ORI,  1'b1, 4'd10, C_IMMWB);
      addVec(1'b0, OP_ADDI, 1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_ADDI, 1'b1, 4'd1,  C_DECODE);
      addVec(1'b0, OP_ADDI, 1'b1, 4'd12, C_ADDIEX);
      addVec(1'b0, OP_ADDI, 1'b1, 4'd10, C_IMMWB);
      addVec(1'b0, OP_J,    1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_J,    1'b1, 4'd1,  C_DECODE);
      addVec(1'b0, OP_J,    1'b1, 4'd11, C_JUMP);
      addVec(1'b0, OP_BAD,  1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_BAD,  1'b1, 4'd1,  C_DECILL);
      addVec(1'b0, OP_J,    1'b0, 4'd0,  C_FSTALL);
      addVec(1'b0, OP_J,    1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_J,    1'b1, 4'd1,  C_DECODE);
      addVec(1'b0, OP_J,    1'b1, 4'd11, C_JUMP);
      addVec(1'b0, OP_SW,   1'b1, 4'd0,  C_FETCH);
      addVec(1'b0, OP_SW,   1'b1, 4'd1,  C_DECODE);
      addVec(1'b0, OP_SW,   1'b1, 4'd2,  C_MEMADR);
      addVec(1'b0, OP_SW,   1'b1, 4'd5,  C_MEMWR);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].rdy);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i), state, ctrl, vecs[i].expState, vecs[i].expCtrl);
         nextCycle();
      end

      // Store stalled in MEMWR, then reset lands mid-wait.
      applyStimulus(1'b0, OP_SW, 1'b1);
      @(negedge clk);
      checkOutput("sw_fetch", state, ctrl, 4'd0, C_FETCH);
      nextCycle();
      @(negedge clk);
      checkOutput("sw_decode", state, ctrl, 4'd1, C_DECODE);
      nextCycle();
      @(negedge clk);
      checkOutput("sw_memadr", state, ctrl, 4'd2, C_MEMADR);
      nextCycle();
      applyStimulus(1'b0, OP_SW, 1'b0);
      @(negedge clk);
      checkOutput("sw_stall0", state, ctrl, 4'd5, C_MEMWR);
      nextCycle();
      @(negedge clk);
      checkOutput("sw_stall1", state, ctrl, 4'd5, C_MEMWR);
      nextCycle();
      applyStimulus(1'b1, OP_SW, 1'b0);
      @(negedge clk);
      checkOutput("sw_reset", state, ctrl, 4'd0, C_ZERO);
      nextCycle();
      applyStimulus(1'b0, OP_R, 1'b1);
      @(negedge clk);
      checkOutput("after_reset", state, ctrl, 4'd0, C_FETCH);

      // Handshake disabled: with mem_ready low the second instance never
      // stalls, while the handshake instance sits in FETCH.
      nextCycle();
      applyStimulus(1'b1, OP_R, 1'b0);
      nextCycle();
      applyStimulus(1'b0, OP_R, 1'b0);
      @(negedge clk);
      checkOutput("nr_fetch", state_nr, ctrlNr, 4'd0, C_FETCH);
      checkOutput("rdy_fetch_stall", state, ctrl, 4'd0, C_FSTALL);
      nextCycle();
      @(negedge clk);
      checkOutput("nr_decode", state_nr, ctrlNr, 4'd1, C_DECODE);
      checkOutput("rdy_fetch_hold", state, ctrl, 4'd0, C_FSTALL);
      nextCycle();
      @(negedge clk);
      checkOutput("nr_exec", state_nr, ctrlNr, 4'd6, C_EXEC);
      nextCycle();
      @(negedge clk);
      checkOutput("nr_aluwb", state_nr, ctrlNr, 4'd7, C_ALUWB);
      nextCycle();
      applyStimulus(1'b0, OP_LW, 1'b0);
      @(negedge clk);
      checkOutput("nr_lw_fetch", state_nr, ctrlNr, 4'd0, C_FETCH);
      nextCycle();
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("nr_lw_memrd", state_nr, ctrlNr, 4'd3, C_MEMRD);
      nextCycle();
      @(negedge clk);
      checkOutput("nr_lw_memwb", state_nr, ctrlNr, 4'd4, C_MEMWB);
      nextCycle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
